// File: rtl/seq_adder.sv
// Multi-cycle adder: sums two WIDTH-bit operands plus carry-in, CHUNK bits per clock,
// behind a start/busy/done handshake. Sum, carry-out, overflow and zero are all registered.
module seq_adder #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned CHUNK = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a_add,
   input  logic [WIDTH-1:0] b_add,
   input  logic             a_c_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             a_c_out,
   output logic             overflow,
   output logic             zero
);

   localparam int unsigned NCHUNK = WIDTH / CHUNK;
   localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

   if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
      $error("seq_adder: CHUNK must divide WIDTH");
   end

   typedef enum logic {IDLE, RUN} state_e;

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [WIDTH-1:0]   psum_q, psum_d;
   logic               carry_q, carry_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [WIDTH-1:0]   sum_q, sum_d;
   logic               c_out_q, c_out_d;
   logic               ovf_q, ovf_d;
   logic               zero_q, zero_d;

   logic [CHUNK-1:0]   chunk_a;
   logic [CHUNK-1:0]   chunk_b;
   logic [CHUNK:0]     chunk_res;
   int unsigned        off;

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         psum_q  <= '0;
         carry_q <= 1'b0;
         idx_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         sum_q   <= '0;
         c_out_q <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         psum_q  <= psum_d;
         carry_q <= carry_d;
         idx_q   <= idx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         sum_q   <= sum_d;
         c_out_q <= c_out_d;
         ovf_q   <= ovf_d;
         zero_q  <= zero_d;
      end
   end

   // Next-state logic; the chunk adder is the only carry chain, CHUNK+1 bits long
   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      psum_d    = psum_q;
      carry_d   = carry_q;
      idx_d     = idx_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      sum_d     = sum_q;
      c_out_d   = c_out_q;
      ovf_d     = ovf_q;
      zero_d    = zero_q;

      off       = 32'(idx_q) * CHUNK;
      chunk_a   = a_q[off +: CHUNK];
      chunk_b   = b_q[off +: CHUNK];
      chunk_res = {1'b0, chunk_a} + {1'b0, chunk_b} + (CHUNK + 1)'(carry_q);

      case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = a_add;
               b_d     = b_add;
               carry_d = a_c_in;
               psum_d  = '0;
               idx_d   = '0;
               busy_d  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            psum_d[off +: CHUNK] = chunk_res[CHUNK-1:0];
            carry_d              = chunk_res[CHUNK];
            idx_d                = idx_q + IDX_W'(1);
            // Last chunk: publish results straight from the merged partial sum
            if (idx_q == LAST_IDX) begin
               sum_d   = psum_d;
               c_out_d = chunk_res[CHUNK];
               ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (psum_d[WIDTH-1] != a_q[WIDTH-1]);
               zero_d  = (psum_d == '0);
               done_d  = 1'b1;
               busy_d  = 1'b0;
               idx_d   = '0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign sum      = sum_q;
   assign a_c_out  = c_out_q;
   assign overflow = ovf_q;
   assign zero     = zero_q;

endmodule
